// File: rtl/arm_exec_datapath.sv
// Execute-stage slice: barrel shifter on operand B, ALU with NZCV flags, address register with +INC_STEP.
// Optional RRX shift (mode 100) is enabled by defining ARM_DATAPATH_RRX_EN.
module arm_exec_datapath #(
    parameter int WIDTH    = 32,
    parameter int INC_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic [2:0]       shift_mode,
    input  logic [4:0]       shift_count,
    input  logic             invert_a,
    input  logic             invert_b,
    input  logic             is_logic,
    input  logic [2:0]       logic_idx,
    input  logic             cin,
    input  logic             alu_en,
    input  logic             ale,
    input  logic             ainc,
    input  logic             abe,
    output logic [WIDTH-1:0] shifter_out,
    output logic [WIDTH-1:0] alu_result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [WIDTH-1:0] incrementer,
    output logic [WIDTH-1:0] addr
);

    logic               sh_c;
    logic [2*WIDTH-1:0] rot;
    logic [WIDTH-1:0]   a_op, b_op, res;
    logic [WIDTH:0]     sum;
    logic               res_c, res_v;
    logic [WIDTH-1:0]   ar_q;

    assign rot = {bus_b, bus_b} >> shift_count;

    // Extended operands let the carry fall out of the shift as the extra bit.
    always_comb begin
        shifter_out = bus_b;
        sh_c        = cin;
        case (shift_mode)
            3'b000: if (shift_count != 5'd0) {sh_c, shifter_out} = {1'b0, bus_b} << shift_count;
            3'b001: if (shift_count != 5'd0) {shifter_out, sh_c} = {bus_b, 1'b0} >> shift_count;
            3'b010: if (shift_count != 5'd0) {shifter_out, sh_c} = $signed({bus_b, 1'b0}) >>> shift_count;
            3'b011: if (shift_count != 5'd0) begin
                shifter_out = rot[WIDTH-1:0];
                sh_c        = rot[WIDTH-1];
            end
`ifdef ARM_DATAPATH_RRX_EN
            3'b100: begin
                shifter_out = {cin, bus_b[WIDTH-1:1]};
                sh_c        = bus_b[0];
            end
`endif
            default: ;
        endcase
    end

    assign a_op = invert_a ? ~bus_a : bus_a;
    assign b_op = invert_b ? ~shifter_out : shifter_out;
    assign sum  = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
        if (is_logic) begin
            res_c = sh_c;
            res_v = flag_v;
            case (logic_idx)
                3'b000:  res = a_op & b_op;
                3'b001:  res = a_op | b_op;
                3'b010:  res = a_op ^ b_op;
                3'b011:  res = b_op;
                default: res = a_op;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
        end else if (alu_en) begin
            alu_result <= res;
            flag_n     <= res[WIDTH-1];
            flag_z     <= (res == '0);
            flag_c     <= res_c;
            flag_v     <= res_v;
        end
    end

    assign incrementer = ar_q + WIDTH'(INC_STEP);

    // ale takes the result registered before this edge, not the one being captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ar_q <= '0;
        else if (ale)  ar_q <= alu_result;
        else if (ainc) ar_q <= incrementer;
    end

    assign addr = abe ? ar_q : '0;

endmodule

// File: tb/tb_arm_exec_datapath.sv
// Directed bench for arm_exec_datapath with hand-computed expectations.
module tb_arm_exec_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_a, bus_b;
    logic [2:0]  shift_mode;
    logic [4:0]  shift_count;
    logic        invert_a, invert_b, is_logic;
    logic [2:0]  logic_idx;
    logic        cin, alu_en, ale, ainc, abe;
    logic [31:0] shifter_out, alu_result, incrementer, addr;
    logic        flag_n, flag_z, flag_c, flag_v;

    int compared   = 0;
    int mismatched = 0;

    arm_exec_datapath #(.WIDTH(32), .INC_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus_a(bus_a), .bus_b(bus_b),
        .shift_mode(shift_mode), .shift_count(shift_count),
        .invert_a(invert_a), .invert_b(invert_b), .is_logic(is_logic),
        .logic_idx(logic_idx), .cin(cin), .alu_en(alu_en), .ale(ale),
        .ainc(ainc), .abe(abe), .shifter_out(shifter_out),
        .alu_result(alu_result), .flag_n(flag_n), .flag_z(flag_z),
        .flag_c(flag_c), .flag_v(flag_v), .incrementer(incrementer),
        .addr(addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_nzcv(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode,
                      input logic [4:0] cnt, input logic ia, input logic ib, input logic lg,
                      input logic [2:0] li, input logic c);
        bus_a = a; bus_b = b; shift_mode = mode; shift_count = cnt;
        invert_a = ia; invert_b = ib; is_logic = lg; logic_idx = li; cin = c;
    endtask

    initial begin
        rst_n = 1'b0;
        op(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        alu_en = 1'b0; ale = 1'b0; ainc = 1'b0; abe = 1'b1;
        #12;
        check("reset_result", alu_result, 32'h0);
        check_nzcv("reset_flags", 4'b0000);
        check("reset_addr", addr, 32'h0);
        check("reset_inc", incrementer, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD immediate
        op(32'hFFFFFFF0, 32'h0000000F, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        alu_en = 1'b1;
        tick();
        check("add_result", alu_result, 32'hFFFFFFFF);
        check_nzcv("add_flags", 4'b1000);

        // carry out with zero result
        op(32'hFFFFFFF0, 32'h00000010, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        check("carry_result", alu_result, 32'h0);
        check_nzcv("carry_flags", 4'b0110);

        // SUB with signed overflow
        op(32'h80000000, 32'h00000001, 3'b000, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
        tick();
        check("sub_result", alu_result, 32'h7FFFFFFF);
        check_nzcv("sub_flags", 4'b0011);

        // EOR: C from shifter (cin at count 0), V held from SUB
        op(32'hFFFFFFF0, 32'h0000000F, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0);
        tick();
        check("eor_result", alu_result, 32'hFFFFFFFF);
        check_nzcv("eor_flags", 4'b1001);

        // ROR #4 through pass-B logic op
        op(32'h0, 32'h0000000F, 3'b011, 5'd4, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0);
        #1;
        check("ror_shift", shifter_out, 32'hF0000000);
        tick();
        check_nzcv("ror_flags", 4'b1011);

        // ASR #31 of negative value
        op(32'h0, 32'h80000000, 3'b010, 5'd31, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1);
        #1;
        check("asr_shift", shifter_out, 32'hFFFFFFFF);
        tick();
        check_nzcv("asr_flags", 4'b1001);

        // LSL #4: carry is bit 28
        op(32'h0, 32'hF0000001, 3'b000, 5'd4, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0);
        #1;
        check("lsl_shift", shifter_out, 32'h00000010);
        tick();
        check_nzcv("lsl_flags", 4'b0011);

        // LSR #1
        op(32'h0, 32'h00000003, 3'b001, 5'd1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        #1;
        check("lsr_shift", shifter_out, 32'h00000001);

        // mode 100 with count 3
        op(32'h0, 32'h00000005, 3'b100, 5'd3, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1);
        #1;
`ifdef ARM_DATAPATH_RRX_EN
        check("mode4_shift", shifter_out, 32'h80000002);
`else
        check("mode4_shift", shifter_out, 32'h00000005);
`endif

        // alu_en low holds result and flags
        alu_en = 1'b0;
        op(32'h12345678, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        check("hold_result", alu_result, 32'h00000010);
        check_nzcv("hold_flags", 4'b0011);

        // address register load and increment
        alu_en = 1'b1;
        op(32'h00000100, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        alu_en = 1'b0; ale = 1'b1;
        tick();
        check("ale_addr", addr, 32'h00000100);
        ale = 1'b0; ainc = 1'b1;
        tick();
        tick();
        ainc = 1'b0;
        check("ainc_addr", addr, 32'h00000108);
        abe = 1'b0;
        #1;
        check("abe_off", addr, 32'h0);
        abe = 1'b1;

        // ale with alu_en in the same cycle takes the old result
        op(32'h00000200, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        alu_en = 1'b1; ale = 1'b1;
        tick();
        check("same_addr", addr, 32'h00000100);
        check("same_result", alu_result, 32'h00000200);

        // ale priority over ainc, then wrap
        op(32'hFFFFFFFC, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        ale = 1'b0;
        tick();
        alu_en = 1'b0; ale = 1'b1; ainc = 1'b1;
        tick();
        check("prio_addr", addr, 32'hFFFFFFFC);
        check("wrap_inc", incrementer, 32'h0);
        ale = 1'b0;
        tick();
        ainc = 1'b0;
        check("wrap_addr", addr, 32'h0);

        // async reset mid-sequence
        ale = 1'b1;
        tick();
        check("pre_rst_addr", addr, 32'hFFFFFFFC);
        ale = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_result", alu_result, 32'h0);
        check_nzcv("arst_flags", 4'b0000);
        check("arst_addr", addr, 32'h0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
